// File: rtl/hazard_scheduler.sv
// Scoreboard-based issue controller for the 16-bit PMIPS pipeline: stalls on RAW hazards and unresolved BEQ.
// Optional HAZARD_PERF_EN adds the stall_cycles performance counter output.
module hazard_scheduler #(
  parameter int WB_LATENCY = 3,
  parameter int BR_LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ifid_instr,
  output logic        issue,
  output logic        pc_stall,
  output logic        bubble,
  output logic [7:0]  busy_mask
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    BR_WAIT
  } state_t;

  localparam logic [1:0] WB_LOAD = 2'(WB_LATENCY);
  localparam logic [1:0] BR_LOAD = 2'(BR_LATENCY);

  state_t     state;
  state_t     next_state;
  logic [1:0] cnt [8];
  logic [1:0] br_cnt;

  logic [2:0] op;
  logic [2:0] rs;
  logic [2:0] rt;
  logic [2:0] rd;
  logic       reads_rs;
  logic       reads_rt;
  logic       writes;
  logic [2:0] dest;
  logic       is_beq;
  logic       hazard;
  logic       issue_raw;
  logic       load;
  logic       unused_imm;

  assign op = ifid_instr[15:13];
  assign rs = ifid_instr[12:10];
  assign rt = ifid_instr[9:7];
  assign rd = ifid_instr[6:4];
  assign unused_imm = ^ifid_instr[3:0];

  // Which register fields each opcode reads and writes; unknown opcodes act as NOPs
  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    dest     = 3'd0;
    case (op)
      3'd0: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
        writes   = 1'b1;
        dest     = rd;
      end
      3'd2, 3'd6: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      3'd3, 3'd5: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        dest     = rt;
      end
      default: ;
    endcase
  end

  assign is_beq = (op == 3'd2);
  assign hazard = (reads_rs && (rs != 3'd0) && (cnt[rs] != 2'd0)) ||
                  (reads_rt && (rt != 3'd0) && (cnt[rt] != 2'd0));

  always_comb begin
    next_state = state;
    issue_raw  = 1'b0;
    case (state)
      INIT: next_state = RUN;
      RUN: begin
        issue_raw = !hazard;
        if (issue_raw && is_beq) next_state = BR_WAIT;
      end
      BR_WAIT: begin
        if (br_cnt == 2'd1) next_state = RUN;
      end
      default: next_state = INIT;
    endcase
  end

  // Outputs are forced quiet while reset is held so the pipeline never launches during reset
  assign issue    = issue_raw && !reset;
  assign pc_stall = !issue;
  assign bubble   = !issue;
  assign load     = issue && writes && (dest != 3'd0);

  always_comb begin
    busy_mask = 8'd0;
    for (int r = 0; r < 8; r++) begin
      busy_mask[r] = !reset && (cnt[r] != 2'd0);
    end
  end

  // A fresh load on the destination takes priority over the per-cycle countdown
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= INIT;
      br_cnt <= 2'd0;
      for (int r = 0; r < 8; r++) cnt[r] <= 2'd0;
    end else begin
      state <= next_state;
      if (state == RUN && issue && is_beq) br_cnt <= BR_LOAD;
      else if (state == BR_WAIT && br_cnt != 2'd0) br_cnt <= br_cnt - 2'd1;
      for (int r = 0; r < 8; r++) begin
        if (load && dest == 3'(r)) cnt[r] <= WB_LOAD;
        else if (cnt[r] != 2'd0) cnt[r] <= cnt[r] - 2'd1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= 16'd0;
    end else if (!issue && state != INIT && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Table-driven bench for hazard_scheduler with a queue of expected outputs per driven cycle.
// A second instance with BR_LATENCY = 1 covers the short branch shadow.
module tb_hazard_scheduler;

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        e_issue;
    logic [7:0]  e_busy;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] ifid_instr;
  logic        issue, pc_stall, bubble;
  logic [7:0]  busy_mask;
  logic        reset2;
  logic [15:0] instr2;
  logic        issue2, pc_stall2, bubble2;
  logic [7:0]  busy_mask2;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles, stall_cycles2;
`endif

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clock = ~clock;

  hazard_scheduler #(.WB_LATENCY(3), .BR_LATENCY(3)) dut (
    .clock(clock), .reset(reset), .ifid_instr(ifid_instr),
    .issue(issue), .pc_stall(pc_stall), .bubble(bubble), .busy_mask(busy_mask)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  hazard_scheduler #(.WB_LATENCY(3), .BR_LATENCY(1)) dut2 (
    .clock(clock), .reset(reset2), .ifid_instr(instr2),
    .issue(issue2), .pc_stall(pc_stall2), .bubble(bubble2), .busy_mask(busy_mask2)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles2)
`endif
  );

  function automatic logic [15:0] mk(input int op, input int rs, input int rt, input int rd);
    return {3'(op), 3'(rs), 3'(rt), 3'(rd), 4'b0000};
  endfunction

  task automatic add(input logic r, input logic [15:0] i, input logic e, input logic [7:0] b);
    vec_t v;
    v.rst = r; v.instr = i; v.e_issue = e; v.e_busy = b;
    tbl.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int idx, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, idx, act, req);
    end
  endtask

  // Drive one cycle on the selected instance, compare its combinational outputs, then clock it
  task automatic applyStimulus(input vec_t v, input bit sel, input int idx);
    vec_t e;
    if (sel) begin reset2 = v.rst; instr2 = v.instr; end
    else begin reset = v.rst; ifid_instr = v.instr; end
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    if (sel) begin
      checkOutput("issue2", idx, int'(issue2), int'(e.e_issue));
      checkOutput("pc_stall2", idx, int'(pc_stall2), int'(!e.e_issue));
      checkOutput("bubble2", idx, int'(bubble2), int'(!e.e_issue));
      checkOutput("busy_mask2", idx, int'(busy_mask2), int'(e.e_busy));
    end else begin
      checkOutput("issue", idx, int'(issue), int'(e.e_issue));
      checkOutput("pc_stall", idx, int'(pc_stall), int'(!e.e_issue));
      checkOutput("bubble", idx, int'(bubble), int'(!e.e_issue));
      checkOutput("busy_mask", idx, int'(busy_mask), int'(e.e_busy));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic runTable(input bit sel, input int base);
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], sel, base + i);
    tbl.delete();
  endtask

  initial begin
    logic [15:0] nop, addi1, addi2, rtype, dep, beq, sw0, lw6, sw6, addi4, addr0;
    nop   = mk(7, 0, 0, 0);
    addi1 = mk(3, 0, 1, 0);
    addi2 = mk(3, 0, 2, 0);
    rtype = mk(0, 4, 5, 3);
    dep   = mk(0, 1, 3, 2);
    beq   = mk(2, 4, 5, 0);
    addr0 = mk(3, 0, 0, 0);
    sw0   = mk(6, 0, 0, 0);
    lw6   = mk(5, 0, 6, 0);
    sw6   = mk(6, 0, 6, 0);
    addi4 = mk(3, 0, 4, 0);

    reset = 1'b1; ifid_instr = nop; reset2 = 1'b1; instr2 = nop;
    @(posedge clock);
    #1;

    // reset held two cycles, then INIT, then first issue
    add(1, addi1, 0, 8'h00); add(1, addi1, 0, 8'h00);
    add(0, addi1, 0, 8'h00); add(0, addi1, 1, 8'h00);
    // independent stream
    add(0, addi2, 1, 8'h02); add(0, rtype, 1, 8'h06);
    add(0, nop, 1, 8'h0E); add(0, nop, 1, 8'h0C); add(0, nop, 1, 8'h08);
    // RAW on r1
    add(0, addi1, 1, 8'h00);
    add(0, dep, 0, 8'h02); add(0, dep, 0, 8'h02); add(0, dep, 0, 8'h02);
    add(0, dep, 1, 8'h00);
    add(0, nop, 1, 8'h04); add(0, nop, 1, 8'h04); add(0, nop, 1, 8'h04);
    // branch shadow
    add(0, beq, 1, 8'h00);
    add(0, addi1, 0, 8'h00); add(0, addi1, 0, 8'h00); add(0, addi1, 0, 8'h00);
    add(0, addi1, 1, 8'h00);
    add(0, nop, 1, 8'h02); add(0, nop, 1, 8'h02); add(0, nop, 1, 8'h02);
    add(0, nop, 1, 8'h00);
    // r0 never busy, lw r6 -> sw r6 stalls 3
    add(0, addr0, 1, 8'h00); add(0, sw0, 1, 8'h00);
    add(0, lw6, 1, 8'h00);
    add(0, sw6, 0, 8'h40); add(0, sw6, 0, 8'h40); add(0, sw6, 0, 8'h40);
    add(0, sw6, 1, 8'h00);
    // beq with its own RAW hazard stalls first, then enters the branch wait
    add(0, addi4, 1, 8'h00);
    add(0, beq, 0, 8'h10); add(0, beq, 0, 8'h10); add(0, beq, 0, 8'h10);
    add(0, beq, 1, 8'h00);
    add(0, nop, 0, 8'h00); add(0, nop, 0, 8'h00); add(0, nop, 0, 8'h00);
    add(0, nop, 1, 8'h00);
    // reset during the second bubble of a RAW stall
    add(0, addi1, 1, 8'h00);
    add(0, dep, 0, 8'h02);
    add(1, dep, 0, 8'h00);
    add(0, dep, 0, 8'h00);
    add(0, dep, 1, 8'h00);
    add(0, nop, 1, 8'h04);
    runTable(1'b0, 0);

    // perf counter: cleared by reset, three stalls from one RAW sequence
    add(1, nop, 0, 8'h00);
    runTable(1'b0, 100);
`ifdef HAZARD_PERF_EN
    checkOutput("stall_cycles_reset", 101, int'(stall_cycles), 0);
`endif
    add(0, nop, 0, 8'h00);
    add(0, addi1, 1, 8'h00);
    add(0, dep, 0, 8'h02); add(0, dep, 0, 8'h02); add(0, dep, 0, 8'h02);
    add(0, dep, 1, 8'h00);
    runTable(1'b0, 110);
`ifdef HAZARD_PERF_EN
    checkOutput("stall_cycles_raw", 116, int'(stall_cycles), 3);
`endif

    // BR_LATENCY = 1 gives exactly one bubble
    add(1, nop, 0, 8'h00);
    add(0, nop, 0, 8'h00);
    add(0, beq, 1, 8'h00);
    add(0, addi1, 0, 8'h00);
    add(0, addi1, 1, 8'h00);
    add(0, nop, 1, 8'h02);
    runTable(1'b1, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
